uart_rx: RTL and testbench



---
 rtl/uart_rx.sv | 155 +++++++++++++++
 tb/tb_uart_rx.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit start validation and valid/ready byte handoff.
// Define UART_RX_MAJORITY_EN to take each bit sample as a 2-of-3 vote over three cycles.
module uart_rx #(
   parameter int unsigned CLK_FREQ  = 50_000_000,
   parameter int unsigned BAUD_RATE = 115200
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] data_out,
   output logic       valid,
   input  logic       ready,
   output logic       frame_err,
   output logic       overrun
);

   localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
   localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
   localparam int unsigned CW           = $clog2(CLKS_PER_BIT);

   localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      StIdle,
      StStartBit,
      StDataBits,
      StStopBit,
      StWaitIdle
   } state_e;

   state_e        state;
   logic          rx_meta;
   logic          rx_s;
   logic [CW-1:0] clk_count;
   logic [2:0]    bit_index;
   logic [7:0]    shift;
   logic          sample;

   // Both flops reset high so a reset never looks like a start bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
      end
   end

`ifdef UART_RX_MAJORITY_EN
   logic [1:0] rx_hist;
   logic [2:0] window;

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_hist <= 2'b11;
      end else begin
         rx_hist <= {rx_hist[0], rx_s};
      end
   end

   // Current rx_s plus the two previous cycles; vote keeps sample edges unchanged.
   assign window = {rx_hist, rx_s};
   assign sample = (window[0] & window[1]) | (window[0] & window[2]) | (window[1] & window[2]);
`else
   assign sample = rx_s;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= StIdle;
         clk_count <= '0;
         bit_index <= 3'd0;
         shift     <= 8'h00;
         data_out  <= 8'h00;
         valid     <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         frame_err <= 1'b0;
         overrun   <= 1'b0;
         if (valid && ready) begin
            valid <= 1'b0;
         end

         unique case (state)
            StIdle: begin
               clk_count <= '0;
               bit_index <= 3'd0;
               if (!rx_s) begin
                  state <= StStartBit;
               end
            end

            StStartBit: begin
               if (clk_count == HALF_LAST) begin
                  clk_count <= '0;
                  bit_index <= 3'd0;
                  state     <= sample ? StIdle : StDataBits;
               end else begin
                  clk_count <= clk_count + 1'b1;
               end
            end

            StDataBits: begin
               if (clk_count == BIT_LAST) begin
                  clk_count        <= '0;
                  shift[bit_index] <= sample;
                  if (bit_index == 3'd7) begin
                     bit_index <= 3'd0;
                     state     <= StStopBit;
                  end else begin
                     bit_index <= bit_index + 3'd1;
                  end
               end else begin
                  clk_count <= clk_count + 1'b1;
               end
            end

            StStopBit: begin
               if (clk_count == BIT_LAST) begin
                  clk_count <= '0;
                  bit_index <= 3'd0;
                  if (sample) begin
                     // A load overrides the accept-clear above; overrun only if unaccepted.
                     data_out <= shift;
                     valid    <= 1'b1;
                     overrun  <= valid && !ready;
                     state    <= StIdle;
                  end else begin
                     frame_err <= 1'b1;
                     state     <= StWaitIdle;
                  end
               end else begin
                  clk_count <= clk_count + 1'b1;
               end
            end

            StWaitIdle: begin
               clk_count <= '0;
               bit_index <= 3'd0;
               if (rx_s) begin
                  state <= StIdle;
               end
            end

            default: begin
               state <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: event-level line model predicts byte/flag timing, compared every cycle.
module tb_uart_rx;

   localparam int unsigned CPB = 16;
   localparam int unsigned HALF = 8;
   // Pin fall (driven just after edge n) to stop-sample edge: 2 sync flops + IDLE detect.
   localparam int unsigned LAT = 3 + HALF + 9 * CPB;

   logic       clk;
   logic       rst;
   logic       rx;
   logic       ready;
   logic [7:0] data_out;
   logic       valid;
   logic       frame_err;
   logic       overrun;

   uart_rx #(
      .CLK_FREQ (16),
      .BAUD_RATE(1)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .rx       (rx),
      .data_out (data_out),
      .valid    (valid),
      .ready    (ready),
      .frame_err(frame_err),
      .overrun  (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int unsigned cyc;
      bit          is_byte;
      logic [7:0]  data;
   } ev_t;

   typedef struct {
      string       name;
      logic [31:0] act;
      logic [31:0] exp;
   } lit_t;

   ev_t         ev_q[$];
   lit_t        lit_q[$];
   int unsigned rise_cyc[$];
   logic [7:0]  rise_dat[$];

   int unsigned cyc = 0;
   int unsigned c_now;
   int unsigned ev_rd = 0;
   int unsigned lit_rd = 0;
   logic        m_valid = 1'b0;
   logic [7:0]  m_data = 8'h00;
   logic        m_fe = 1'b0;
   logic        m_ovr = 1'b0;
   bit          cmp_en = 1'b0;
   bit          done = 1'b0;
   logic        valid_prev = 1'b0;
   int unsigned vcyc = 0;
   int unsigned fe_cnt = 0;
   int unsigned ov_cnt = 0;
   int unsigned n_checks = 0;
   int unsigned n_pass = 0;

   // Reference: each sent frame becomes one event at its stop edge; handshake rules applied here.
   always @(posedge clk) begin
      c_now = cyc + 1;
      cyc   <= c_now;
      m_fe  <= 1'b0;
      m_ovr <= 1'b0;
      if (rst) begin
         m_valid <= 1'b0;
         m_data  <= 8'h00;
         ev_rd   <= ev_q.size();
      end else begin
         if (ev_rd < ev_q.size() && ev_q[ev_rd].cyc == c_now) begin
            ev_rd <= ev_rd + 1;
            if (ev_q[ev_rd].is_byte) begin
               m_data  <= ev_q[ev_rd].data;
               m_valid <= 1'b1;
               m_ovr   <= m_valid && !ready;
            end else begin
               m_fe <= 1'b1;
               if (m_valid && ready) m_valid <= 1'b0;
            end
         end else if (m_valid && ready) begin
            m_valid <= 1'b0;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   // Single compare process: per-cycle model checks, monitor, and queued literal checks.
   always @(negedge clk) begin
      if (cmp_en) begin
         check("valid", {31'd0, valid}, {31'd0, m_valid});
         check("data_out", {24'd0, data_out}, {24'd0, m_data});
         check("frame_err", {31'd0, frame_err}, {31'd0, m_fe});
         check("overrun", {31'd0, overrun}, {31'd0, m_ovr});
         if (valid && !valid_prev) begin
            rise_cyc.push_back(cyc);
            rise_dat.push_back(data_out);
         end
         if (valid) vcyc++;
         if (frame_err) fe_cnt++;
         if (overrun) ov_cnt++;
         valid_prev = valid;
      end
      while (lit_rd < lit_q.size()) begin
         check(lit_q[lit_rd].name, lit_q[lit_rd].act, lit_q[lit_rd].exp);
         lit_rd++;
      end
   end

   task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
      lit_t t;
      t.name = name;
      t.act  = act;
      t.exp  = exp;
      lit_q.push_back(t);
   endtask

   function automatic logic [31:0] rise_c(input int unsigned i);
      return (i < rise_cyc.size()) ? rise_cyc[i] : 32'hffff_ffff;
   endfunction

   function automatic logic [31:0] rise_d(input int unsigned i);
      return (i < rise_dat.size()) ? {24'd0, rise_dat[i]} : 32'hffff_ffff;
   endfunction

   // Called just after a rising edge; returns just after a rising edge.
   task automatic hold(input logic v, input int unsigned n);
      rx = v;
      if (n != 0) begin
         repeat (n) @(posedge clk);
         #1;
      end
   endtask

   task automatic push_ev(input int unsigned at, input bit is_byte, input logic [7:0] b);
      ev_t e;
      e.cyc     = at;
      e.is_byte = is_byte;
      e.data    = b;
      ev_q.push_back(e);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop);
      push_ev(cyc + LAT, stop, b);
      hold(1'b0, CPB);
      for (int i = 0; i < 8; i++) hold(b[i], CPB);
      hold(stop, CPB);
   endtask

   int unsigned rb;
   int unsigned n0;
   int unsigned fb;
   int unsigned ob;
   int unsigned vb;
   logic [7:0]  rb_byte;
   logic [7:0]  maj_exp;

   initial begin
      rst   = 1'b1;
      rx    = 1'b1;
      ready = 1'b0;
      @(posedge clk);
      #1;
      cmp_en = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      lit("reset_valid", {31'd0, valid}, 32'd0);
      lit("reset_data", {24'd0, data_out}, 32'd0);
      lit("reset_frame_err", {31'd0, frame_err}, 32'd0);
      lit("reset_overrun", {31'd0, overrun}, 32'd0);
      rst = 1'b0;

      // Clean byte, ready held high: one-cycle valid at start + 155.
      ready = 1'b1;
      hold(1'b1, 20);
      rb = rise_cyc.size(); fb = fe_cnt; vb = vcyc;
      n0 = cyc;
      send_frame(8'hA5, 1'b1);
      hold(1'b1, 4);
      lit("clean_rises", rise_cyc.size() - rb, 32'd1);
      lit("clean_cycle", rise_c(rb), n0 + 155);
      lit("clean_data", rise_d(rb), 32'h0000_00A5);
      lit("clean_valid_len", vcyc - vb, 32'd1);
      lit("clean_frame_err", fe_cnt - fb, 32'd0);

      // Back-to-back frames, no idle gap.
      rb = rise_cyc.size();
      send_frame(8'h00, 1'b1);
      send_frame(8'hFF, 1'b1);
      send_frame(8'h55, 1'b1);
      hold(1'b1, 4);
      lit("b2b_rises", rise_cyc.size() - rb, 32'd3);
      lit("b2b_data0", rise_d(rb), 32'h00);
      lit("b2b_data1", rise_d(rb + 1), 32'hFF);
      lit("b2b_data2", rise_d(rb + 2), 32'h55);
      lit("b2b_gap1", rise_c(rb + 1) - rise_c(rb), 32'd160);
      lit("b2b_gap2", rise_c(rb + 2) - rise_c(rb + 1), 32'd160);

      // 4-cycle glitch, then a clean byte to show the receiver returned to idle.
      rb = rise_cyc.size(); fb = fe_cnt;
      hold(1'b0, 4);
      hold(1'b1, 30);
      lit("glitch_rises", rise_cyc.size() - rb, 32'd0);
      lit("glitch_frame_err", fe_cnt - fb, 32'd0);
      send_frame(8'h5C, 1'b1);
      hold(1'b1, 4);
      lit("post_glitch_data", rise_d(rb), 32'h5C);

      // Stop bit low.
      rb = rise_cyc.size(); fb = fe_cnt;
      send_frame(8'h3C, 1'b0);
      hold(1'b1, 16);
      lit("ferr_count", fe_cnt - fb, 32'd1);
      lit("ferr_rises", rise_cyc.size() - rb, 32'd0);

      // Break: 30 bit times low gives exactly one frame error.
      fb = fe_cnt;
      push_ev(cyc + LAT, 1'b0, 8'h00);
      hold(1'b0, 30 * CPB);
      hold(1'b1, 16);
      lit("break_frame_err", fe_cnt - fb, 32'd1);
      rb = rise_cyc.size();
      send_frame(8'h12, 1'b1);
      hold(1'b1, 4);
      lit("post_break_data", rise_d(rb), 32'h12);

      // Overrun with ready low.
      ready = 1'b0;
      ob = ov_cnt; rb = rise_cyc.size();
      send_frame(8'h11, 1'b1);
      send_frame(8'h22, 1'b1);
      hold(1'b1, 4);
      lit("ovr_count", ov_cnt - ob, 32'd1);
      lit("ovr_data", {24'd0, data_out}, 32'h22);
      lit("ovr_valid", {31'd0, valid}, 32'd1);
      lit("ovr_rises", rise_cyc.size() - rb, 32'd1);
      ready = 1'b1;
      @(posedge clk);
      #1;
      lit("ovr_accept_clears", {31'd0, valid}, 32'd0);

      // Reset during bit 4 of 0x96 while an earlier byte is still pending.
      ready = 1'b0;
      send_frame(8'h5A, 1'b1);
      hold(1'b1, 4);
      lit("pre_rst_valid", {31'd0, valid}, 32'd1);
      rb_byte = 8'h96;
      hold(1'b0, CPB);
      for (int i = 0; i < 4; i++) hold(rb_byte[i], CPB);
      hold(rb_byte[4], 8);
      rx  = 1'b1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      lit("rst_mid_valid", {31'd0, valid}, 32'd0);
      lit("rst_mid_data", {24'd0, data_out}, 32'd0);
      lit("rst_mid_frame_err", {31'd0, frame_err}, 32'd0);
      lit("rst_mid_overrun", {31'd0, overrun}, 32'd0);
      rb = rise_cyc.size(); fb = fe_cnt;
      ready = 1'b1;
      hold(1'b1, 20 * CPB);
      lit("rst_mid_no_byte", rise_cyc.size() - rb, 32'd0);
      lit("rst_mid_no_flag", fe_cnt - fb, 32'd0);
      send_frame(8'h96, 1'b1);
      hold(1'b1, 4);
      lit("post_rst_data", rise_d(rb), 32'h96);

      // One-cycle high spike landing on the bit-3 sample edge of 0x00.
`ifdef UART_RX_MAJORITY_EN
      maj_exp = 8'h00;
`else
      maj_exp = 8'h08;
`endif
      rb = rise_cyc.size();
      push_ev(cyc + LAT, 1'b1, maj_exp);
      hold(1'b0, 4 * CPB + 8);
      hold(1'b1, 1);
      hold(1'b0, 7 + 4 * CPB);
      hold(1'b1, CPB);
      hold(1'b1, 4);
      lit("spike_data", rise_d(rb), {24'd0, maj_exp});

      // Random bytes, gaps, bad stop bits and random ready.
      done = 1'b0;
      fork
         begin
            for (int f = 0; f < 40; f++) begin
               logic [7:0] b;
               bit         bad;
               b   = 8'($urandom);
               bad = ($urandom_range(0, 7) == 0);
               send_frame(b, !bad);
               if (bad) hold(1'b1, 8 + $urandom_range(0, 10));
               else hold(1'b1, $urandom_range(0, 12));
            end
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(posedge clk);
               #1;
               ready = 1'($urandom_range(0, 1));
            end
         end
      join
      ready = 1'b1;
      hold(1'b1, 200);
      lit("all_events_retired", ev_rd, ev_q.size());

      @(negedge clk);
      @(negedge clk);
      #1;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
